mult_acc: RTL and testbench

MULT_ACC -- requirements
Module: mult_acc

---
 rtl/mult_acc.sv | 122 ++++++++++++
 tb/tb_mult_acc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_acc.sv
// ============================================================================
//  Module      : mult_acc
//  Description : Sequential unsigned multiply-accumulate, N = Q*D + R.
//                Shift-and-add, one multiplicand bit per clock, LSB first.
//                Optional remainder check (rem_ok) when MULT_ACC_CHECK_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_acc #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   Q,
  input  logic [W-1:0]   D,
  input  logic [W-1:0]   R,
  output logic           idle,
  output logic           finish,
  output logic [2*W-1:0] N
`ifdef MULT_ACC_CHECK_EN
  ,
  output logic           rem_ok
`endif
);

  // Counter is wide enough to index every multiplicand bit.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_d;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_n;
  logic           w_accept;
  logic           w_last;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_sum;
`ifdef MULT_ACC_CHECK_EN
  logic [W-1:0]   r_r;
  logic           r_rem_ok;
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  // Partial product for the current multiplicand bit; the sum never
  // exceeds 2W bits because (2^W-1)^2 + (2^W-1) < 2^(2W).
  assign w_addend = r_q[r_cnt] ? ({{W{1'b0}}, r_d} << r_cnt) : '0;
  assign w_sum    = r_acc + w_addend;

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: RUN lasts exactly W edges, DONE exactly one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == C_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, accumulate during RUN, publish
  // the result only on the final RUN edge so N never shows partial sums.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_q      <= '0;
      r_d      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_n      <= '0;
`ifdef MULT_ACC_CHECK_EN
      r_r      <= '0;
      r_rem_ok <= 1'b0;
`endif
    end else if (w_accept) begin
      r_q   <= Q;
      r_d   <= D;
      r_acc <= {{W{1'b0}}, R};
      r_cnt <= '0;
`ifdef MULT_ACC_CHECK_EN
      r_r   <= R;
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_n      <= w_sum;
`ifdef MULT_ACC_CHECK_EN
        r_rem_ok <= (r_r < r_d);
`endif
      end
    end
  end

  assign idle   = (r_state == S_IDLE);
  assign finish = (r_state == S_DONE);
  assign N      = r_n;
`ifdef MULT_ACC_CHECK_EN
  assign rem_ok = r_rem_ok;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_acc.sv
// ============================================================================
//  Module      : tb_mult_acc
//  Description : Scoreboard bench for mult_acc (W=8). Stimulus pushes the
//                hand-computed result and the edge at which finish must
//                appear; a monitor pops and compares on every finish.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_acc;

  localparam int W = 8;

  logic           CLK;
  logic           reset;
  logic           start;
  logic [W-1:0]   Q;
  logic [W-1:0]   D;
  logic [W-1:0]   R;
  logic           idle;
  logic           finish;
  logic [2*W-1:0] N;
`ifdef MULT_ACC_CHECK_EN
  logic           rem_ok;
`endif

  mult_acc #(.W(W)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .start  (start),
    .Q      (Q),
    .D      (D),
    .R      (R),
    .idle   (idle),
    .finish (finish),
    .N      (N)
`ifdef MULT_ACC_CHECK_EN
    ,
    .rem_ok (rem_ok)
`endif
  );

  typedef struct {
    logic [15:0] n;
    logic        rem;
    int          fin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every finish must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (reset && finish) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_finish: finish=1 at edge %0d, expected no finish", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("N", 32'(N), 32'(e.n));
        chk("finish_edge", edge_cnt, e.fin);
`ifdef MULT_ACC_CHECK_EN
        chk("rem_ok", 32'(rem_ok), 32'(e.rem));
`endif
      end
    end
  end

  // Drive operands and start for one cycle; optionally record expectation.
  task automatic issue(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                       input logic [15:0] n, input logic rem, input bit push,
                       output int e0);
    @(negedge CLK);
    Q = q; D = d; R = r; start = 1'b1;
    @(posedge CLK);
    #1;
    e0 = edge_cnt;
    start = 1'b0;
    if (push) sb.push_back('{n: n, rem: rem, fin: e0 + W});
  endtask

  // Count negedges with idle low until idle returns; bounded.
  task automatic wait_idle(output int cyc);
    bit done;
    done = 0;
    cyc  = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (idle) done = 1;
      else      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: idle still 0 after 40 cycles, expected 1");
    end
  endtask

  task automatic do_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                       input logic [15:0] n, input logic rem);
    int e0;
    int c;
    issue(q, d, r, n, rem, 1'b1, e0);
    wait_idle(c);
    chk("idle_low_cycles", c + 1, 10);  // c excludes accept-to-first-negedge offset; 9 low cycles
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int e0;
    int prev;
    int c;
    reset = 1'b0;
    start = 1'b0;
    Q = '0; D = '0; R = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_idle",   32'(idle),   32'd1);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_N",      32'(N),      32'd0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic vectors: 13*7+5=96, 255*255+255=65280, 0*200+17, 200*0+33, 2*128+1
    do_op(8'd13,  8'd7,   8'd5,   16'h0060, 1'b1);
    // N holds the previous result while the next operation runs
    issue(8'd255, 8'd255, 8'd255, 16'hFF00, 1'b0, 1'b1, e0);
    repeat (3) @(negedge CLK);
    chk("N_hold_during_run", 32'(N), 32'h0060);
    wait_idle(c);
    do_op(8'd0,   8'd200, 8'd17,  16'h0011, 1'b1);
    do_op(8'd200, 8'd0,   8'd33,  16'h0021, 1'b0);
    do_op(8'd2,   8'd128, 8'd1,   16'h0101, 1'b1);

    // Start pulse during RUN ignored; operand changes after accept ignored
    issue(8'd13, 8'd7, 8'd5, 16'h0060, 1'b1, 1'b1, e0);
    Q = 8'hAA; D = 8'h55; R = 8'h33;
    repeat (3) @(negedge CLK);
    Q = 8'd1; D = 8'd1; R = 8'd1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle(c);
    repeat (12) @(negedge CLK);
    chk("N_after_ignored_start", 32'(N), 32'h0060);
    chk("idle_after_ignored_start", 32'(idle), 32'd1);

    // Reset mid-RUN: immediate clear, no finish afterwards
    issue(8'd50, 8'd50, 8'd50, 16'h0000, 1'b0, 1'b0, e0);
    repeat (3) @(posedge CLK);
    #2;
    reset = 1'b0;
    #1;
    chk("midrun_rst_idle",   32'(idle),   32'd1);
    chk("midrun_rst_finish", 32'(finish), 32'd0);
    chk("midrun_rst_N",      32'(N),      32'd0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (15) @(negedge CLK);
    chk("post_rst_idle", 32'(idle), 32'd1);
    chk("post_rst_N",    32'(N),    32'd0);

    // Start held high: accepts every 10 edges, each with its own operands
    @(negedge CLK);
    Q = 8'd3; D = 8'd4; R = 8'd5; start = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] n_exp;
      logic        r_exp;
      case (k)
        0:       begin n_exp = 16'h0011; r_exp = 1'b0; end
        1:       begin n_exp = 16'h006E; r_exp = 1'b0; end
        default: begin n_exp = 16'h00FF; r_exp = 1'b1; end
      endcase
      @(posedge CLK);
      #1;
      e0 = edge_cnt;
      sb.push_back('{n: n_exp, rem: r_exp, fin: e0 + W});
      if (k > 0) chk("held_start_spacing", e0 - prev, 10);
      prev = e0;
      wait_idle(c);
      case (k)
        0:       begin Q = 8'd10;  D = 8'd10; R = 8'd10; end
        1:       begin Q = 8'd255; D = 8'd1;  R = 8'd0;  end
        default: start = 1'b0;
      endcase
    end

`ifdef MULT_ACC_CHECK_EN
    do_op(8'd3, 8'd7, 8'd9, 16'd30, 1'b0);
    do_op(8'd3, 8'd7, 8'd6, 16'd27, 1'b1);
    do_op(8'd5, 8'd0, 8'd0, 16'd0,  1'b0);
`endif

    repeat (15) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
